// File: rtl/bmp_pkg.sv
// Shared constants, header-byte generator and FSM encoding for the BMP frame writer.
// Everything here is evaluated at elaboration time or folds into constant tables.
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BMP_INFO_SIZE = 40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_PIXELS = 2'd2,
        ST_DONE   = 2'd3
    } bmp_state_e;

    function automatic int bmp_row_bytes(input int width);
        return (3 * width + 3) & ~3;
    endfunction

    function automatic int bmp_pad(input int width);
        return bmp_row_bytes(width) - 3 * width;
    endfunction

    // Byte n of the 54-byte file + info header; multi-byte fields are little-endian.
    function automatic logic [7:0] bmp_hdr_byte(input int n, input int width, input int height);
        logic [31:0] img_bytes;
        logic [31:0] field;
        int          ofs;
        img_bytes = 32'(bmp_row_bytes(width) * height);
        field     = '0;
        ofs       = 0;
        if (n == 0) return 8'h42;
        if (n == 1) return 8'h4D;
        if (n >= 2 && n <= 5) begin
            field = 32'(BMP_HDR_BYTES) + img_bytes;
            ofs   = n - 2;
        end else if (n >= 10 && n <= 13) begin
            field = 32'(BMP_HDR_BYTES);
            ofs   = n - 10;
        end else if (n >= 14 && n <= 17) begin
            field = 32'(BMP_INFO_SIZE);
            ofs   = n - 14;
        end else if (n >= 18 && n <= 21) begin
            field = 32'(width);
            ofs   = n - 18;
        end else if (n >= 22 && n <= 25) begin
            field = 32'(height);
            ofs   = n - 22;
        end else if (n >= 26 && n <= 27) begin
            field = 32'd1;
            ofs   = n - 26;
        end else if (n >= 28 && n <= 29) begin
            field = 32'd24;
            ofs   = n - 28;
        end else if (n >= 34 && n <= 37) begin
            field = img_bytes;
            ofs   = n - 34;
        end
        return 8'(field >> (8 * ofs));
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational header lane generator: returns the LANES header bytes of one beat.
// Lanes past the end of the 54-byte header read as zero with byte enable cleared.
module bmp_header_rom
    import bmp_pkg::*;
#(
    parameter int IMG_W  = 768,
    parameter int IMG_H  = 512,
    parameter int LANES  = 6,
    parameter int BEAT_W = 4
)(
    input  logic [BEAT_W-1:0]  beat,
    output logic [8*LANES-1:0] data,
    output logic [LANES-1:0]   be
);

    always_comb begin
        data = '0;
        be   = '0;
        for (int j = 0; j < LANES; j++) begin
            if (int'(beat) * LANES + j < BMP_HDR_BYTES) begin
                data[8*j +: 8] = bmp_hdr_byte(int'(beat) * LANES + j, IMG_W, IMG_H);
                be[j]          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmp_frame_writer.sv
// Streams a 24-bit BMP (header, bottom-up rows, 4-byte row padding) to a byte-addressed
// frame memory through a single registered write stage with valid/ready handshakes.
module bmp_frame_writer
    import bmp_pkg::*;
#(
    parameter int IMG_W       = 768,
    parameter int IMG_H       = 512,
    parameter int PIX_PER_CLK = 2,
    parameter int ADDR_W      = 24
)(
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [24*PIX_PER_CLK-1:0] in_data,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [24*PIX_PER_CLK-1:0] wr_data,
    output logic [3*PIX_PER_CLK-1:0]  wr_be,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int LANES     = 3 * PIX_PER_CLK;
    localparam int ROW_BYTES = bmp_row_bytes(IMG_W);
    localparam int PAD       = bmp_pad(IMG_W);
    localparam int HDR_BEATS = (BMP_HDR_BYTES + LANES - 1) / LANES;
    localparam int HB_W      = $clog2(HDR_BEATS + 1);
    localparam int COL_W     = $clog2(IMG_W + 1);
    localparam int ROW_W     = $clog2(IMG_H + 1);

    localparam logic [ADDR_W-1:0] FIRST_ROW = ADDR_W'(BMP_HDR_BYTES + (IMG_H - 1) * ROW_BYTES);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_BYTES);
    localparam logic [ADDR_W-1:0] PAD_OFS   = ADDR_W'(3 * IMG_W);
    localparam logic [ADDR_W-1:0] LANE_STEP = ADDR_W'(LANES);
    localparam logic [LANES-1:0]  PAD_BE    = LANES'((1 << PAD) - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HDR_BEATS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - PIX_PER_CLK);
    localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(PIX_PER_CLK);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);

    bmp_state_e         state;
    logic [HB_W-1:0]    hdr_beat;
    logic [ADDR_W-1:0]  hdr_addr;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  col_off;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               pad_pending;
    logic               last_issued;
    logic [8*LANES-1:0] hdr_data;
    logic [LANES-1:0]   hdr_be;

    logic load;
    logic pix_acc;
    logic pad_acc;
    logic col_end;
    logic row_end;

    bmp_header_rom #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .LANES  (LANES),
        .BEAT_W (HB_W)
    ) u_hdr (
        .beat (hdr_beat),
        .data (hdr_data),
        .be   (hdr_be)
    );

    // The output register may take a new beat when empty or being drained this cycle.
    assign load     = !wr_valid || wr_ready;
    assign in_ready = (state == ST_PIXELS) && load && !pad_pending && !last_issued;
    assign pix_acc  = in_valid && in_ready;
    assign pad_acc  = (state == ST_PIXELS) && pad_pending && !last_issued && load;
    assign col_end  = (col == COL_LAST);
    assign row_end  = pad_acc || (pix_acc && col_end && (PAD == 0));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_be       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            hdr_beat    <= '0;
            hdr_addr    <= '0;
            row_base    <= '0;
            col_off     <= '0;
            col         <= '0;
            row         <= '0;
            pad_pending <= 1'b0;
            last_issued <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (wr_valid && wr_ready) wr_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_HEADER;
                        busy        <= 1'b1;
                        hdr_beat    <= '0;
                        hdr_addr    <= '0;
                        row_base    <= FIRST_ROW;
                        col_off     <= '0;
                        col         <= '0;
                        row         <= '0;
                        pad_pending <= 1'b0;
                        last_issued <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    if (load) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= hdr_addr;
                        wr_data  <= hdr_data;
                        wr_be    <= hdr_be;
                        hdr_beat <= hdr_beat + 1'b1;
                        hdr_addr <= hdr_addr + LANE_STEP;
                        if (hdr_beat == HB_LAST) state <= ST_PIXELS;
                    end
                end
                ST_PIXELS: begin
                    // Completion waits for the final beat to leave the output register.
                    if (last_issued) begin
                        if (wr_ready) begin
                            state       <= ST_DONE;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            last_issued <= 1'b0;
                        end
                    end else if (pad_acc) begin
                        wr_valid    <= 1'b1;
                        wr_addr     <= row_base + PAD_OFS;
                        wr_data     <= '0;
                        wr_be       <= PAD_BE;
                        pad_pending <= 1'b0;
                    end else if (pix_acc) begin
                        wr_valid <= 1'b1;
                        wr_addr  <= row_base + col_off;
                        wr_data  <= in_data;
                        wr_be    <= '1;
                        if (col_end) begin
                            col     <= '0;
                            col_off <= '0;
                            if (PAD > 0) pad_pending <= 1'b1;
                        end else begin
                            col     <= col + COL_STEP;
                            col_off <= col_off + LANE_STEP;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Rows are written bottom-up, so the base walks downwards one row at a time.
            if (row_end) begin
                row_base <= row_base - ROW_STEP;
                row      <= row + 1'b1;
                if (row == ROW_LAST) last_issued <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bmp_frame_writer.sv
// Directed bench for bmp_frame_writer: four parameterisations sharing one clock and reset.
module tb_bmp_frame_writer;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [23:0] addr;
        logic [95:0] data;
        logic [11:0] be;
    } beat_t;

    // u_d: default 768x512, 2 px/clk
    logic        start_d = 0, in_valid_d = 0, wr_ready_d = 1;
    logic [47:0] in_data_d = '0;
    logic        in_ready_d, wr_valid_d, busy_d, frame_done_d;
    logic [23:0] wr_addr_d;
    logic [47:0] wr_data_d;
    logic [5:0]  wr_be_d;
    // u_s: 5x2, 1 px/clk
    logic        start_s = 0, in_valid_s = 0, wr_ready_s = 1;
    logic [23:0] in_data_s = '0;
    logic        in_ready_s, wr_valid_s, busy_s, frame_done_s;
    logic [23:0] wr_addr_s;
    logic [23:0] wr_data_s;
    logic [2:0]  wr_be_s;
    // u_m: 6x5, 2 px/clk, PAD = 2
    logic        start_m = 0, in_valid_m = 0, wr_ready_m = 1;
    logic [47:0] in_data_m = '0;
    logic        in_ready_m, wr_valid_m, busy_m, frame_done_m;
    logic [23:0] wr_addr_m;
    logic [47:0] wr_data_m;
    logic [5:0]  wr_be_m;
    // u_q: 8x1, 4 px/clk
    logic        start_q = 0, in_valid_q = 0, wr_ready_q = 1;
    logic [95:0] in_data_q = '0;
    logic        in_ready_q, wr_valid_q, busy_q, frame_done_q;
    logic [23:0] wr_addr_q;
    logic [95:0] wr_data_q;
    logic [11:0] wr_be_q;

    bmp_frame_writer u_d (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_d), .in_valid(in_valid_d),
        .in_ready(in_ready_d), .in_data(in_data_d), .wr_valid(wr_valid_d), .wr_ready(wr_ready_d),
        .wr_addr(wr_addr_d), .wr_data(wr_data_d), .wr_be(wr_be_d), .busy(busy_d),
        .frame_done(frame_done_d)
    );

    bmp_frame_writer #(.IMG_W(5), .IMG_H(2), .PIX_PER_CLK(1), .ADDR_W(24)) u_s (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .in_data(in_data_s), .wr_valid(wr_valid_s), .wr_ready(wr_ready_s),
        .wr_addr(wr_addr_s), .wr_data(wr_data_s), .wr_be(wr_be_s), .busy(busy_s),
        .frame_done(frame_done_s)
    );

    bmp_frame_writer #(.IMG_W(6), .IMG_H(5), .PIX_PER_CLK(2), .ADDR_W(24)) u_m (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_m), .in_valid(in_valid_m),
        .in_ready(in_ready_m), .in_data(in_data_m), .wr_valid(wr_valid_m), .wr_ready(wr_ready_m),
        .wr_addr(wr_addr_m), .wr_data(wr_data_m), .wr_be(wr_be_m), .busy(busy_m),
        .frame_done(frame_done_m)
    );

    bmp_frame_writer #(.IMG_W(8), .IMG_H(1), .PIX_PER_CLK(4), .ADDR_W(24)) u_q (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start_q), .in_valid(in_valid_q),
        .in_ready(in_ready_q), .in_data(in_data_q), .wr_valid(wr_valid_q), .wr_ready(wr_ready_q),
        .wr_addr(wr_addr_q), .wr_data(wr_data_q), .wr_be(wr_be_q), .busy(busy_q),
        .frame_done(frame_done_q)
    );

    beat_t q_d[$];
    beat_t q_s[$];
    beat_t q_q[$];
    int fd_d = 0, fd_s = 0, fd_m = 0, fd_q = 0;
    logic [7:0] mem_m [0:255];
    logic [7:0] exp_m [0:255];
    int wcnt_m = 0;
    logic        prev_stall_m = 1'b0;
    logic [78:0] prev_m = '0;

    // Inputs change right at the falling edge; monitors look 2 time units later.
    always @(negedge HCLK) begin
        #2;
        if (wr_valid_d && wr_ready_d) q_d.push_back({wr_addr_d, 96'(wr_data_d), 12'(wr_be_d)});
        if (wr_valid_s && wr_ready_s) q_s.push_back({wr_addr_s, 96'(wr_data_s), 12'(wr_be_s)});
        if (wr_valid_q && wr_ready_q) q_q.push_back({wr_addr_q, wr_data_q, wr_be_q});
        if (frame_done_d) fd_d++;
        if (frame_done_s) fd_s++;
        if (frame_done_q) fd_q++;
        if (frame_done_m) begin
            fd_m++;
            check_eq("busy_low_at_done_m", 128'(busy_m), 128'(0));
        end
        if (wr_valid_m && wr_ready_m) begin
            wcnt_m++;
            for (int j = 0; j < 6; j++)
                if (wr_be_m[j]) mem_m[(int'(wr_addr_m) + j) & 255] = wr_data_m[8*j +: 8];
        end
        if (prev_stall_m && HRESETn)
            check_eq("stall_hold_m", 128'({wr_valid_m, wr_addr_m, wr_data_m, wr_be_m}), 128'(prev_m));
        prev_stall_m = HRESETn && wr_valid_m && !wr_ready_m;
        prev_m       = {wr_valid_m, wr_addr_m, wr_data_m, wr_be_m};
    end

    task automatic clear_m();
        for (int a = 0; a < 256; a++) mem_m[a] = 8'hEE;
        wcnt_m = 0;
        fd_m   = 0;
    endtask

    task automatic pulse_start_m();
        @(negedge HCLK);
        start_m = 1'b1;
        @(negedge HCLK);
        start_m = 1'b0;
    endtask

    task automatic feed_m(input bit stall, input int n_beats);
        int b = 0;
        for (int cyc = 0; cyc < 400 && b < n_beats; cyc++) begin
            @(negedge HCLK);
            in_data_m  = {24'(2 * b + 1), 24'(2 * b)};
            in_valid_m = 1'b1;
            wr_ready_m = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready_m) b++;
        end
        check_eq("feed_count_m", 128'(b), 128'(n_beats));
    endtask

    task automatic drain_m(input bit stall);
        for (int i = 0; i < 400 && fd_m == 0; i++) begin
            @(negedge HCLK);
            in_valid_m = 1'b0;
            wr_ready_m = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        @(negedge HCLK);
        wr_ready_m = 1'b1;
        repeat (3) @(negedge HCLK);
    endtask

    // Expected 6x5 image: header bytes derived by hand, pixel i = 24'(i) stored B,G,R.
    task automatic compare_m(input string run);
        for (int a = 0; a < 256; a++) exp_m[a] = (a < 154) ? 8'h00 : 8'hEE;
        exp_m[0] = 8'h42;  exp_m[1] = 8'h4D;  exp_m[2]  = 8'h9A; exp_m[10] = 8'h36;
        exp_m[14] = 8'h28; exp_m[18] = 8'h06; exp_m[22] = 8'h05; exp_m[26] = 8'h01;
        exp_m[28] = 8'h18; exp_m[34] = 8'h64;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++)
                exp_m[54 + (4 - r) * 20 + 3 * c] = 8'(r * 6 + c);
        for (int a = 0; a < 256; a++)
            check_eq($sformatf("%s_mem[%0d]", run, a), 128'(mem_m[a]), 128'(exp_m[a]));
        check_eq({run, "_writes"}, 128'(wcnt_m), 128'(29));
        check_eq({run, "_done_cycles"}, 128'(fd_m), 128'(1));
    endtask

    initial begin
        int idle_rdy;
        int b;
        int snap;

        // Reset state
        repeat (3) @(negedge HCLK);
        check_eq("rst_outs_d", 128'({in_ready_d, wr_valid_d, wr_addr_d, wr_data_d, wr_be_d, busy_d, frame_done_d}), '0);
        check_eq("rst_outs_m", 128'({in_ready_m, wr_valid_m, wr_addr_m, wr_data_m, wr_be_m, busy_m, frame_done_m}), '0);
        HRESETn = 1'b1;

        // in_valid held in IDLE is never accepted
        idle_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            in_valid_d = 1'b1;
            #1;
            if (in_ready_d) idle_rdy++;
        end
        @(negedge HCLK);
        in_valid_d = 1'b0;
        check_eq("idle_in_ready_d", 128'(idle_rdy), 128'(0));
        check_eq("idle_writes_d", 128'(q_d.size()), 128'(0));
        check_eq("idle_busy_d", 128'(busy_d), 128'(0));

        // Default frame: header beats and first row placement
        start_d = 1'b1;
        @(negedge HCLK);
        start_d = 1'b0;
        check_eq("busy_after_start_d", 128'(busy_d), 128'(1));
        for (int i = 0; i < 50 && q_d.size() < 9; i++) @(negedge HCLK);
        check_eq("hdr0_addr_d", 128'(q_d[0].addr), 128'(0));
        check_eq("hdr0_data_d", 128'(q_d[0].data), 128'(48'h0012_0036_4D42));
        check_eq("hdr0_be_d", 128'(q_d[0].be), 128'(6'h3F));
        check_eq("hdr3_data_d", 128'(q_d[3].data), 128'(48'h0200_0000_0300));
        check_eq("hdr4_data_d", 128'(q_d[4].data), 128'(48'h0018_0001_0000));
        check_eq("hdr8_addr_d", 128'(q_d[8].addr), 128'(48));
        check_eq("hdr8_data_d", 128'(q_d[8].data), 128'(0));

        // Four pixel beats, with a start pulse in the middle that must be ignored
        b = 0;
        for (int cyc = 0; cyc < 40 && b < 4; cyc++) begin
            @(negedge HCLK);
            start_d    = (b == 2);
            in_data_d  = {24'(2 * b + 1), 24'(2 * b)};
            in_valid_d = 1'b1;
            #1;
            if (in_ready_d) b++;
        end
        @(negedge HCLK);
        start_d    = 1'b0;
        in_valid_d = 1'b0;
        repeat (4) @(negedge HCLK);
        check_eq("beats_total_d", 128'(q_d.size()), 128'(13));
        check_eq("pix0_addr_d", 128'(q_d[9].addr), 128'(1177398));
        check_eq("pix0_data_d", 128'(q_d[9].data), 128'(48'h000001_000000));
        check_eq("pix0_be_d", 128'(q_d[9].be), 128'(6'h3F));
        check_eq("pix1_addr_d", 128'(q_d[10].addr), 128'(1177404));
        check_eq("pix3_addr_d", 128'(q_d[12].addr), 128'(1177416));
        check_eq("pix3_data_d", 128'(q_d[12].data), 128'(48'h000007_000006));
        check_eq("busy_held_d", 128'(busy_d), 128'(1));

        // 5x2, one pixel per beat, PAD = 1
        @(negedge HCLK);
        start_s = 1'b1;
        @(negedge HCLK);
        start_s = 1'b0;
        b = 0;
        for (int cyc = 0; cyc < 100 && b < 10; cyc++) begin
            @(negedge HCLK);
            in_data_s  = 24'hA0B0C0 + 24'h010101 * 24'(b);
            in_valid_s = 1'b1;
            #1;
            if (in_ready_s) b++;
        end
        @(negedge HCLK);
        in_valid_s = 1'b0;
        for (int i = 0; i < 100 && fd_s == 0; i++) @(negedge HCLK);
        repeat (3) @(negedge HCLK);
        check_eq("beats_total_s", 128'(q_s.size()), 128'(30));
        check_eq("hdr0_data_s", 128'(q_s[0].data), 128'(24'h564D42));
        check_eq("hdr11_data_s", 128'(q_s[11].data), 128'(24'h002000));
        check_eq("hdr17_addr_s", 128'(q_s[17].addr), 128'(51));
        for (int k = 0; k < 5; k++)
            check_eq($sformatf("row0_px%0d_addr_s", k), 128'(q_s[18 + k].addr), 128'(70 + 3 * k));
        check_eq("row0_px0_data_s", 128'(q_s[18].data), 128'(24'hA0B0C0));
        check_eq("pad0_addr_s", 128'(q_s[23].addr), 128'(85));
        check_eq("pad0_be_s", 128'(q_s[23].be), 128'(3'b001));
        check_eq("pad0_data_s", 128'(q_s[23].data[7:0]), 128'(0));
        check_eq("row1_px0_addr_s", 128'(q_s[24].addr), 128'(54));
        check_eq("row1_px0_data_s", 128'(q_s[24].data), 128'(24'hA5B5C5));
        check_eq("pad1_addr_s", 128'(q_s[29].addr), 128'(69));
        check_eq("done_cycles_s", 128'(fd_s), 128'(1));

        // 8x1, four pixels per beat, PAD = 0
        @(negedge HCLK);
        start_q = 1'b1;
        @(negedge HCLK);
        start_q = 1'b0;
        b = 0;
        for (int cyc = 0; cyc < 50 && b < 2; cyc++) begin
            @(negedge HCLK);
            in_data_q  = (b == 0) ? 96'h040404_030303_020202_010101 : 96'h080808_070707_060606_050505;
            in_valid_q = 1'b1;
            #1;
            if (in_ready_q) b++;
        end
        @(negedge HCLK);
        in_valid_q = 1'b0;
        for (int i = 0; i < 50 && fd_q == 0; i++) @(negedge HCLK);
        repeat (3) @(negedge HCLK);
        check_eq("beats_total_q", 128'(q_q.size()), 128'(7));
        check_eq("hdr1_data_q", 128'(q_q[1].data), 128'(96'h0001_0000_0008_0000_0028_0000));
        check_eq("hdr4_addr_q", 128'(q_q[4].addr), 128'(48));
        check_eq("hdr4_be_q", 128'(q_q[4].be), 128'(12'h03F));
        check_eq("pix0_addr_q", 128'(q_q[5].addr), 128'(54));
        check_eq("pix0_data_q", 128'(q_q[5].data), 128'(96'h040404_030303_020202_010101));
        check_eq("pix1_addr_q", 128'(q_q[6].addr), 128'(66));
        check_eq("pix1_be_q", 128'(q_q[6].be), 128'(12'hFFF));
        check_eq("done_cycles_q", 128'(fd_q), 128'(1));
        check_eq("busy_after_q", 128'(busy_q), 128'(0));

        // 6x5 full frame without stalls
        clear_m();
        pulse_start_m();
        feed_m(1'b0, 15);
        drain_m(1'b0);
        compare_m("clean");

        // Reset in the middle of row 3, then a full frame
        clear_m();
        pulse_start_m();
        feed_m(1'b0, 10);
        @(negedge HCLK);
        in_valid_m = 1'b0;
        HRESETn    = 1'b0;
        @(negedge HCLK);
        check_eq("midrst_outs_m", 128'({in_ready_m, wr_valid_m, wr_addr_m, wr_data_m, wr_be_m, busy_m, frame_done_m}), '0);
        check_eq("midrst_outs_d", 128'({wr_valid_d, wr_addr_d, busy_d}), '0);
        snap    = wcnt_m;
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        check_eq("abort_no_done_m", 128'(fd_m), 128'(0));
        check_eq("abort_no_writes_m", 128'(wcnt_m), 128'(snap));
        clear_m();
        pulse_start_m();
        feed_m(1'b0, 15);
        drain_m(1'b0);
        compare_m("after_rst");

        // Random write back-pressure must not change the image
        clear_m();
        pulse_start_m();
        feed_m(1'b1, 15);
        drain_m(1'b1);
        compare_m("stall");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
